// File: rtl/branch_target_buffer.sv
// Branch target buffer with per-entry saturating direction counters.
// Direct-mapped or 2-way set-associative (LRU); lookup is combinational, update is on the clock edge.
module branch_target_buffer #(
  parameter int ENTRIES      = 16,
  parameter int WAYS         = 1,
  parameter int COUNTER_BITS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] curr_pc,
  output logic [31:0] bp_pc,
  output logic        btb_hit,
  output logic        pred_taken,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] branch_target,
  input  logic        branch_flush
);

  localparam int SETS  = ENTRIES / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [WAY_W-1:0]        way_t;
  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [TAG_W-1:0]        tag_t;
  typedef logic [COUNTER_BITS-1:0] ctr_t;

  localparam ctr_t CTR_MAX  = {COUNTER_BITS{1'b1}};
  localparam ctr_t CTR_ONE  = ctr_t'(1'b1);
  localparam ctr_t CTR_WEAK = CTR_ONE << (COUNTER_BITS - 1);

  logic        valid_q  [WAYS][SETS];
  logic        valid_d  [WAYS][SETS];
  tag_t        tag_q    [WAYS][SETS];
  tag_t        tag_d    [WAYS][SETS];
  logic [31:0] target_q [WAYS][SETS];
  logic [31:0] target_d [WAYS][SETS];
  ctr_t        ctr_q    [WAYS][SETS];
  ctr_t        ctr_d    [WAYS][SETS];
  logic        lru_q    [SETS];
  logic        lru_d    [SETS];

  idx_t        l_idx_s;
  tag_t        l_tag_s;
  logic        l_hit_s;
  ctr_t        l_ctr_s;
  logic [31:0] l_tgt_s;

  idx_t        u_idx_s;
  tag_t        u_tag_s;
  logic        u_hit_s;
  way_t        u_hit_way_s;
  way_t        victim_s;
  way_t        wr_way_s;
  ctr_t        u_ctr_s;

  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^{curr_pc[1:0], update_pc[1:0]};

  // Fetch-side lookup: OR-combine the (at most one) matching way.
  always_comb begin
    l_idx_s = curr_pc[IDX_W+1:2];
    l_tag_s = curr_pc[31:IDX_W+2];
    l_hit_s = 1'b0;
    l_ctr_s = '0;
    l_tgt_s = 32'h0000_0000;
    for (int w = 0; w < WAYS; w++) begin
      l_hit_s = l_hit_s | (valid_q[w][l_idx_s] && (tag_q[w][l_idx_s] == l_tag_s));
      l_ctr_s = l_ctr_s | ((valid_q[w][l_idx_s] && (tag_q[w][l_idx_s] == l_tag_s))
                           ? ctr_q[w][l_idx_s] : '0);
      l_tgt_s = l_tgt_s | ((valid_q[w][l_idx_s] && (tag_q[w][l_idx_s] == l_tag_s))
                           ? target_q[w][l_idx_s] : 32'h0000_0000);
    end
  end

  assign btb_hit    = l_hit_s;
  assign pred_taken = l_hit_s & l_ctr_s[COUNTER_BITS-1];
  assign bp_pc      = pred_taken ? l_tgt_s : (curr_pc + 32'd4);

  // Resolve-side tag match and victim choice (first invalid way, else LRU).
  always_comb begin
    u_idx_s     = update_pc[IDX_W+1:2];
    u_tag_s     = update_pc[31:IDX_W+2];
    u_hit_s     = 1'b0;
    u_hit_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      u_hit_s     = u_hit_s | (valid_q[w][u_idx_s] && (tag_q[w][u_idx_s] == u_tag_s));
      u_hit_way_s = u_hit_way_s | ((valid_q[w][u_idx_s] && (tag_q[w][u_idx_s] == u_tag_s))
                                   ? way_t'(w) : '0);
    end
    if (WAYS == 1) begin
      victim_s = '0;
    end else if (!valid_q[0][u_idx_s]) begin
      victim_s = '0;
    end else if (!valid_q[WAYS-1][u_idx_s]) begin
      victim_s = way_t'(WAYS - 1);
    end else begin
      victim_s = way_t'(lru_q[u_idx_s]);
    end
    wr_way_s = u_hit_s ? u_hit_way_s : victim_s;
    u_ctr_s  = ctr_q[wr_way_s][u_idx_s];
  end

  // Next-state table contents; flush wins over a same-cycle update.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    lru_d    = lru_q;
    if (branch_flush) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_d[w][s] = 1'b0;
        end
      end
      for (int s = 0; s < SETS; s++) begin
        lru_d[s] = 1'b0;
      end
    end else if (update_en) begin
      if (u_hit_s) begin
        if (update_taken) begin
          ctr_d[wr_way_s][u_idx_s]    = (u_ctr_s == CTR_MAX) ? u_ctr_s : (u_ctr_s + CTR_ONE);
          target_d[wr_way_s][u_idx_s] = branch_target;
        end else begin
          ctr_d[wr_way_s][u_idx_s]    = (u_ctr_s == '0) ? u_ctr_s : (u_ctr_s - CTR_ONE);
        end
        lru_d[u_idx_s] = ~wr_way_s[0];
      end else if (update_taken) begin
        valid_d[wr_way_s][u_idx_s]  = 1'b1;
        tag_d[wr_way_s][u_idx_s]    = u_tag_s;
        target_d[wr_way_s][u_idx_s] = branch_target;
        ctr_d[wr_way_s][u_idx_s]    = CTR_WEAK;
        lru_d[u_idx_s]              = ~wr_way_s[0];
      end else begin
        lru_d[u_idx_s] = lru_q[u_idx_s];
      end
    end else begin
      lru_d = lru_q;
    end
  end

  // Table state registers with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s]  <= 1'b0;
          tag_q[w][s]    <= '0;
          target_q[w][s] <= 32'h0000_0000;
          ctr_q[w][s]    <= '0;
        end
      end
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      lru_q    <= lru_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench: a direct-mapped instance (a_*) and a 2-way instance (b_*).
// Expected lookup results are queued when stimulus is applied and popped when sampled.
module tb_branch_target_buffer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nRST;
  logic [31:0] a_curr_pc, a_bp_pc, a_update_pc, a_branch_target;
  logic        a_hit, a_pred, a_en, a_taken, a_flush;
  logic [31:0] b_curr_pc, b_bp_pc, b_update_pc, b_branch_target;
  logic        b_hit, b_pred, b_en, b_taken, b_flush;

  branch_target_buffer #(.ENTRIES(16), .WAYS(1), .COUNTER_BITS(2)) dut_a (
    .CLK(CLK), .nRST(nRST), .curr_pc(a_curr_pc), .bp_pc(a_bp_pc), .btb_hit(a_hit),
    .pred_taken(a_pred), .update_en(a_en), .update_pc(a_update_pc),
    .update_taken(a_taken), .branch_target(a_branch_target), .branch_flush(a_flush)
  );

  branch_target_buffer #(.ENTRIES(16), .WAYS(2), .COUNTER_BITS(2)) dut_b (
    .CLK(CLK), .nRST(nRST), .curr_pc(b_curr_pc), .bp_pc(b_bp_pc), .btb_hit(b_hit),
    .pred_taken(b_pred), .update_en(b_en), .update_pc(b_update_pc),
    .update_taken(b_taken), .branch_target(b_branch_target), .branch_flush(b_flush)
  );

  typedef struct packed {
    logic        hit;
    logic        pred;
    logic [31:0] bp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic drive(input bit sel, input logic en, input logic [31:0] pc,
                       input logic taken, input logic [31:0] tgt, input logic flush);
    if (sel) begin
      b_en = en; b_update_pc = pc; b_taken = taken; b_branch_target = tgt; b_flush = flush;
    end else begin
      a_en = en; a_update_pc = pc; a_taken = taken; a_branch_target = tgt; a_flush = flush;
    end
  endtask

  task automatic check_lookup(input bit sel, input logic [31:0] pc, input logic hit,
                              input logic pred, input logic [31:0] bp, input string name);
    exp_t        e;
    logic        got_hit, got_pred;
    logic [31:0] got_bp;
    if (sel) b_curr_pc = pc; else a_curr_pc = pc;
    e.hit = hit; e.pred = pred; e.bp = bp;
    sb_q.push_back(e);
    #1;
    got_hit  = sel ? b_hit  : a_hit;
    got_pred = sel ? b_pred : a_pred;
    got_bp   = sel ? b_bp_pc : a_bp_pc;
    e = sb_q.pop_front();
    n_checks++;
    if (got_hit !== e.hit) begin
      n_fail++;
      $display("FAIL %s btb_hit: got %0b expected %0b", name, got_hit, e.hit);
    end
    n_checks++;
    if (got_pred !== e.pred) begin
      n_fail++;
      $display("FAIL %s pred_taken: got %0b expected %0b", name, got_pred, e.pred);
    end
    n_checks++;
    if (got_bp !== e.bp) begin
      n_fail++;
      $display("FAIL %s bp_pc: got %08h expected %08h", name, got_bp, e.bp);
    end
  endtask

  task automatic do_update(input bit sel, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic flush);
    @(negedge CLK);
    drive(sel, 1'b1, pc, taken, tgt, flush);
    @(posedge CLK);
    #1;
    drive(sel, 1'b0, pc, taken, tgt, 1'b0);
  endtask

  task automatic test_reset();
    check_lookup(1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044, "reset_a");
    check_lookup(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044, "reset_b");
  endtask

  task automatic test_allocate();
    @(negedge CLK);
    drive(1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
    check_lookup(1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044, "no_bypass");
    @(posedge CLK);
    #1;
    drive(1'b0, 1'b0, 32'h0000_0040, 1'b0, 32'h0000_0100, 1'b0);
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0100, "alloc_hit");
  endtask

  task automatic test_hysteresis();
    do_update(1'b0, 32'h0000_0040, 1'b0, 32'h0000_0300, 1'b0);
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044, "ctr2_to_1");
    do_update(1'b0, 32'h0000_0040, 1'b0, 32'h0000_0300, 1'b0);
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044, "ctr1_to_0");
    do_update(1'b0, 32'h0000_0040, 1'b0, 32'h0000_0300, 1'b0);
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044, "ctr0_sat");
    do_update(1'b0, 32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044, "ctr0_to_1");
    do_update(1'b0, 32'h0000_0040, 1'b1, 32'h0000_0200, 1'b0);
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0200, "ctr1_to_2");
    do_update(1'b0, 32'h0000_0040, 1'b1, 32'h0000_0200, 1'b0);
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0200, "ctr2_to_3");
    do_update(1'b0, 32'h0000_0040, 1'b1, 32'h0000_0200, 1'b0);
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0200, "ctr3_sat");
    do_update(1'b0, 32'h0000_0040, 1'b0, 32'h0000_0300, 1'b0);
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0200, "ctr3_to_2_tgt_kept");
    do_update(1'b0, 32'h0000_0040, 1'b0, 32'h0000_0300, 1'b0);
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044, "ctr2_to_1_again");
  endtask

  task automatic test_nt_miss_and_wrap();
    do_update(1'b0, 32'h0000_0080, 1'b0, 32'h0000_0900, 1'b0);
    check_lookup(1'b0, 32'h0000_0080, 1'b0, 1'b0, 32'h0000_0084, "nt_miss_no_alloc");
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044, "nt_miss_kept_0x40");
    check_lookup(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, "pc_wrap");
  endtask

  task automatic test_x_inputs();
    @(negedge CLK);
    a_en = 1'b0; a_update_pc = 'x; a_branch_target = 'x; a_taken = 'x;
    repeat (2) @(posedge CLK);
    #1;
    check_lookup(1'b0, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044, "x_while_idle");
    drive(1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
  endtask

  task automatic test_flush();
    do_update(1'b0, 32'h0000_0044, 1'b1, 32'h0000_1044, 1'b0);
    do_update(1'b0, 32'h0000_0048, 1'b1, 32'h0000_1048, 1'b0);
    do_update(1'b0, 32'h0000_004C, 1'b1, 32'h0000_104C, 1'b0);
    do_update(1'b0, 32'h0000_0050, 1'b1, 32'h0000_1050, 1'b0);
    check_lookup(1'b0, 32'h0000_004C, 1'b1, 1'b1, 32'h0000_104C, "pre_flush_hit");
    do_update(1'b0, 32'h0000_00C0, 1'b1, 32'h0000_0CC0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pc;
      pc = 32'h0000_0044 + 32'(4 * i);
      check_lookup(1'b0, pc, 1'b0, 1'b0, pc + 32'd4, "flush_miss");
    end
    check_lookup(1'b0, 32'h0000_00C0, 1'b0, 1'b0, 32'h0000_00C4, "flush_beats_update");
    check_lookup(1'b0, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044, "flush_old_0x40");
  endtask

  task automatic test_lru();
    do_update(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0400, 1'b0);
    do_update(1'b1, 32'h0000_0060, 1'b1, 32'h0000_0600, 1'b0);
    check_lookup(1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0400, "w2_fill0");
    check_lookup(1'b1, 32'h0000_0060, 1'b1, 1'b1, 32'h0000_0600, "w2_fill1");
    do_update(1'b1, 32'h0000_0080, 1'b1, 32'h0000_0800, 1'b0);
    check_lookup(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044, "w2_evict_0x40");
    check_lookup(1'b1, 32'h0000_0060, 1'b1, 1'b1, 32'h0000_0600, "w2_keep_0x60");
    check_lookup(1'b1, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0800, "w2_new_0x80");
    do_update(1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1);
    check_lookup(1'b1, 32'h0000_0060, 1'b0, 1'b0, 32'h0000_0064, "w2_flushed");
    do_update(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0410, 1'b0);
    do_update(1'b1, 32'h0000_0060, 1'b1, 32'h0000_0610, 1'b0);
    do_update(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0420, 1'b0);
    do_update(1'b1, 32'h0000_0080, 1'b1, 32'h0000_0810, 1'b0);
    check_lookup(1'b1, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0420, "w2_touched_kept");
    check_lookup(1'b1, 32'h0000_0060, 1'b0, 1'b0, 32'h0000_0064, "w2_evict_0x60");
    check_lookup(1'b1, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0810, "w2_new_0x80_b");
  endtask

  task automatic test_async_reset();
    do_update(1'b0, 32'h0000_0044, 1'b1, 32'h0000_0500, 1'b0);
    check_lookup(1'b0, 32'h0000_0044, 1'b1, 1'b1, 32'h0000_0500, "pre_async_hit");
    #1;
    nRST = 1'b0;
    check_lookup(1'b0, 32'h0000_0044, 1'b0, 1'b0, 32'h0000_0048, "async_rst_now");
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check_lookup(1'b0, 32'h0000_0044, 1'b0, 1'b0, 32'h0000_0048, "async_rst_cleared");
  endtask

  initial begin
    nRST = 1'b0;
    a_curr_pc = 32'h0000_0000;
    b_curr_pc = 32'h0000_0000;
    drive(1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    drive(1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    test_allocate();
    test_hysteresis();
    test_nt_miss_and_wrap();
    test_x_inputs();
    test_flush();
    test_lru();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
